// File: rtl/ldpc_pkg.sv
// Shared types and sizes for the min-sum decoder back end.
package ldpc_pkg;

  localparam int N_V   = 44;
  localparam int N_C   = 12;
  localparam int N_FP  = 8;
  localparam int ROW_W = $clog2(N_C);
  localparam int CNT_W = $clog2(N_C + 1);

  typedef logic signed [N_FP-1:0] llr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } hd_state_t;

  // Zero slices to 0; every negative value, including the most negative, slices to 1.
  function automatic logic hard_bit(input llr_t llr);
    return (llr < llr_t'(0));
  endfunction

endpackage

// File: rtl/hard_decision_syndrome_parity_row.sv
// Parity of one parity-check row against the current hard-decision word.
module parity_row #(
  parameter int W = 44
) (
  input  logic [W-1:0] bits,
  input  logic [W-1:0] h_row,
  output logic         parity
);

  assign parity = ^(bits & h_row);

endmodule

// File: rtl/hard_decision_syndrome.sv
// Hard-decision slicer and row-serial syndrome check over valid/ready.
// Define DECODE_STATS_EN to add the out_unsat unsatisfied-check counter.
module hard_decision_syndrome
  import ldpc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [N_C*N_V-1:0]  h_matrix,
  input  logic [N_V*N_FP-1:0] in_llr,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N_V-1:0]      out_bits,
  output logic [N_C-1:0]      out_synd,
  output logic                out_ok,
  output logic                out_valid,
  input  logic                out_ready
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]    out_unsat
`endif
);

  hd_state_t        state_q;
  logic [ROW_W-1:0] row_q;
  logic [N_V-1:0]   bits_q;
  logic [N_C-1:0]   synd_q;
  logic [N_C-1:0]   synd_d;
  logic [N_V-1:0]   slice_s;
  logic [N_V-1:0]   h_row_s;
  logic             parity_s;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_ok_q;
`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] unsat_q;
`endif

  // Sign slice of the incoming frame and selection of the row under test.
  always_comb begin
    slice_s = '0;
    for (int v = 0; v < N_V; v++) begin
      slice_s[v] = hard_bit(llr_t'(in_llr[v*N_FP +: N_FP]));
    end
    h_row_s = h_matrix[int'(row_q)*N_V +: N_V];
    synd_d = synd_q;
    synd_d[row_q] = parity_s;
  end

  parity_row #(.W(N_V)) u_parity_row (
    .bits   (bits_q),
    .h_row  (h_row_s),
    .parity (parity_s)
  );

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      bits_q      <= '0;
      synd_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ok_q    <= 1'b0;
`ifdef DECODE_STATS_EN
      unsat_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bits_q     <= slice_s;
            synd_q     <= '0;
            row_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef DECODE_STATS_EN
            unsat_q    <= '0;
`endif
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          synd_q <= synd_d;
`ifdef DECODE_STATS_EN
          unsat_q <= unsat_q + CNT_W'(parity_s);
`endif
          if (row_q == ROW_W'(N_C - 1)) begin
            out_valid_q <= 1'b1;
            out_ok_q    <= ~|synd_d;
            state_q     <= DONE;
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_bits  = bits_q;
  assign out_synd  = synd_q;
  assign out_ok    = out_ok_q;
  assign out_valid = out_valid_q;
`ifdef DECODE_STATS_EN
  assign out_unsat = unsat_q;
`endif

endmodule

// File: tb/tb_hard_decision_syndrome.sv
// Directed, table-driven bench for hard_decision_syndrome, plus stall, reset and back-to-back sequences.
module tb_hard_decision_syndrome;
  import ldpc_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_C*N_V-1:0]  h_matrix;
  logic [N_V*N_FP-1:0] in_llr;
  logic                in_valid;
  logic                in_ready;
  logic [N_V-1:0]      out_bits;
  logic [N_C-1:0]      out_synd;
  logic                out_ok;
  logic                out_valid;
  logic                out_ready;
`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0]    out_unsat;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N_V*N_FP-1:0] llr;
    logic [N_C*N_V-1:0]  h;
    logic [N_V-1:0]      bits;
    logic [N_C-1:0]      synd;
    logic                ok;
    int                  unsat;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  hard_decision_syndrome dut (
    .clk       (clk),
    .rst       (rst),
    .h_matrix  (h_matrix),
    .in_llr    (in_llr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bits  (out_bits),
    .out_synd  (out_synd),
    .out_ok    (out_ok),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DECODE_STATS_EN
    ,
    .out_unsat (out_unsat)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N_V*N_FP-1:0] fill_llr(input logic [7:0] val);
    logic [N_V*N_FP-1:0] r;
    for (int v = 0; v < N_V; v++) r[v*N_FP +: N_FP] = val;
    return r;
  endfunction

  function automatic logic [N_V-1:0] model_bits(input logic [N_V*N_FP-1:0] llr);
    logic [N_V-1:0] b;
    for (int v = 0; v < N_V; v++) b[v] = ($signed(llr[v*N_FP +: N_FP]) < 0);
    return b;
  endfunction

  function automatic logic [N_C-1:0] model_synd(input logic [N_V*N_FP-1:0] llr,
                                                input logic [N_C*N_V-1:0] h);
    logic [N_V-1:0] b;
    logic [N_C-1:0] s;
    int ones;
    b = model_bits(llr);
    for (int r = 0; r < N_C; r++) begin
      ones = 0;
      for (int v = 0; v < N_V; v++) if (b[v] && h[r*N_V + v]) ones++;
      s[r] = ones[0];
    end
    return s;
  endfunction

  // Caller sits at a negedge; returns at the negedge after the accept edge.
  task automatic accept_frame(input vec_t v);
    int n;
    n = 0;
    in_llr   = v.llr;
    h_matrix = v.h;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_llr   = '1;
  endtask

  task automatic wait_out();
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd13);
  endtask

  task automatic check_out(input vec_t v, input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_bits"}, 64'(out_bits), 64'(v.bits));
    check({tag, "_synd"}, 64'(out_synd), 64'(v.synd));
    check({tag, "_ok"}, 64'(out_ok), 64'(v.ok));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
`ifdef DECODE_STATS_EN
    check({tag, "_unsat"}, 64'(out_unsat), 64'(v.unsat));
`endif
  endtask

  task automatic handshake(input vec_t v, input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_bits_kept"}, 64'(out_bits), 64'(v.bits));
    check({tag, "_synd_kept"}, 64'(out_synd), 64'(v.synd));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    accept_frame(v);
    wait_out();
    check_out(v, tag);
    handshake(v, tag);
  endtask

  initial begin
    logic [N_V*N_FP-1:0] fr[4];
    logic [N_C*N_V-1:0]  h6;
    int acc_cyc[4];
    int n_in, n_out;
    bit pend, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_llr = '0; h_matrix = '0;

    vecs[0].llr = fill_llr(8'd20); vecs[0].h = '1;
    vecs[0].bits = 44'h0; vecs[0].synd = 12'h000; vecs[0].ok = 1'b1; vecs[0].unsat = 0;

    vecs[1].llr = fill_llr(8'd5); vecs[1].llr[7:0] = 8'hFB;
    vecs[1].h = '0; vecs[1].h[1:0] = 2'b11;
    vecs[1].bits = 44'h1; vecs[1].synd = 12'h001; vecs[1].ok = 1'b0; vecs[1].unsat = 1;

    vecs[2].llr = fill_llr(8'd1); vecs[2].llr[3*N_FP +: N_FP] = 8'h00; vecs[2].llr[7*N_FP +: N_FP] = 8'h80;
    vecs[2].h = '0;
    for (int r = 0; r < N_C; r++) vecs[2].h[r*N_V + r] = 1'b1;
    vecs[2].bits = 44'h080; vecs[2].synd = 12'h080; vecs[2].ok = 1'b0; vecs[2].unsat = 1;

    vecs[3].llr = fill_llr(8'hFF); vecs[3].h = '0;
    for (int r = 0; r < N_C; r++) for (int v = 0; v <= r; v++) vecs[3].h[r*N_V + v] = 1'b1;
    vecs[3].bits = 44'hFFF_FFFF_FFFF; vecs[3].synd = 12'h555; vecs[3].ok = 1'b0; vecs[3].unsat = 6;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bits", 64'(out_bits), 64'd0);
    check("rst_synd", 64'(out_synd), 64'd0);
    check("rst_ok", 64'(out_ok), 64'd0);
`ifdef DECODE_STATS_EN
    check("rst_unsat", 64'(out_unsat), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Output stall: a second frame offered during DONE must wait for the handshake.
    accept_frame(vecs[1]);
    wait_out();
    in_llr = vecs[2].llr; h_matrix = vecs[2].h; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_bits", 64'(out_bits), 64'(vecs[1].bits));
      check("stall_synd", 64'(out_synd), 64'(vecs[1].synd));
      check("stall_ok", 64'(out_ok), 64'(vecs[1].ok));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_valid", 64'(out_valid), 64'd0);
    check("stall_release_ready", 64'(in_ready), 64'd1);
    accept_frame(vecs[2]);
    wait_out();
    check_out(vecs[2], "after_stall");
    handshake(vecs[2], "after_stall");

    // Reset while the row counter is at 6.
    accept_frame(vecs[3]);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_synd", 64'(out_synd), 64'd0);
    check("midrst_bits", 64'(out_bits), 64'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 64'(seen), 64'd0);
    run_vec(vecs[1], "post_rst");

    // Back-to-back frames against the reference model.
    for (int k = 0; k < 4; k++)
      for (int v = 0; v < N_V; v++) fr[k][v*N_FP +: N_FP] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N_C*N_V; i++) h6[i] = 1'($urandom_range(0, 1));
    h_matrix = h6; in_llr = fr[0]; in_valid = 1'b1; out_ready = 1'b1;
    n_in = 0; n_out = 0; pend = 1'b0;
    for (int c = 0; c < 120 && n_out < 4; c++) begin
      if (pend) begin
        pend = 1'b0;
        n_in++;
        if (n_in < 4) in_llr = fr[n_in];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check($sformatf("b2b%0d_bits", n_out), 64'(out_bits), 64'(model_bits(fr[n_out])));
        check($sformatf("b2b%0d_synd", n_out), 64'(out_synd), 64'(model_synd(fr[n_out], h6)));
        check($sformatf("b2b%0d_ok", n_out), 64'(out_ok), 64'(model_synd(fr[n_out], h6) == '0));
        n_out++;
      end
      if (in_valid && in_ready && n_in < 4) begin
        acc_cyc[n_in] = c;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("b2b_frames_out", 64'(n_out), 64'd4);
    check("b2b_frames_in", 64'(n_in), 64'd4);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b_period%0d", k), 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
